// File: rtl/prbs_delay_timer.sv
// prbs_delay_timer: PRBS-driven random start delay, counted down on i_tick, one-cycle completion pulse.
// Defining PRBS_DELAY_REACTION_EN adds reaction-time measurement after the pulse.
module prbs_delay_timer #(
    parameter int                LFSR_W    = 10,
    parameter logic [LFSR_W-1:0] SEED      = 10'h001,
    parameter int                CNT_W     = 16,
    parameter logic [CNT_W-1:0]  MIN_TICKS = 16'd250
) (
    input  logic i_clk,
    input  logic i_arst,
    input  logic i_tick,
    input  logic i_rstPRBS,
    input  logic i_enPRBS,
    input  logic i_startDelay,
    output logic o_delayComplete,
    output logic o_busy
`ifdef PRBS_DELAY_REACTION_EN
    ,
    input  logic        i_react,
    output logic [15:0] o_reactTicks,
    output logic        o_reactValid
`endif
);
    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        DONE,
`ifdef PRBS_DELAY_REACTION_EN
        REACT,
`endif
        RELEASE
    } state_t;

    state_t            state_q;
    logic [LFSR_W-1:0] lfsr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  n;
`ifdef PRBS_DELAY_REACTION_EN
    logic [15:0]       react_q;
`endif

    assign n = MIN_TICKS + CNT_W'(lfsr_q);

    // An all-zero register would lock up, so it is forced back to SEED
    always_ff @(posedge i_clk or posedge i_arst)
        if (i_arst)
            lfsr_q <= SEED;
        else if (i_rstPRBS || lfsr_q == '0)
            lfsr_q <= SEED;
        else if (i_enPRBS)
            lfsr_q <= {lfsr_q[LFSR_W-2:0], lfsr_q[LFSR_W-1] ^ lfsr_q[6]};

    always_ff @(posedge i_clk or posedge i_arst)
        if (i_arst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            o_delayComplete <= 1'b0;
            o_busy          <= 1'b0;
`ifdef PRBS_DELAY_REACTION_EN
            react_q         <= '0;
            o_reactTicks    <= '0;
            o_reactValid    <= 1'b0;
`endif
        end else begin
            o_delayComplete <= 1'b0;
`ifdef PRBS_DELAY_REACTION_EN
            o_reactValid    <= 1'b0;
`endif
            case (state_q)
                IDLE:
                    if (i_startDelay) begin
                        cnt_q   <= n;
                        state_q <= COUNT;
                        o_busy  <= 1'b1;
                    end
                COUNT:
                    if (!i_startDelay) begin
                        state_q <= IDLE;
                        o_busy  <= 1'b0;
                    end else if (i_tick) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_q         <= DONE;
                            o_delayComplete <= 1'b1;
                        end
                    end
`ifdef PRBS_DELAY_REACTION_EN
                DONE: begin
                    state_q <= REACT;
                    react_q <= '0;
                end
                REACT:
                    if (i_react) begin
                        o_reactTicks <= react_q;
                        o_reactValid <= 1'b1;
                        state_q      <= RELEASE;
                    end else if (i_tick && react_q != 16'hFFFF)
                        react_q <= react_q + 16'd1;
`else
                DONE:
                    state_q <= RELEASE;
`endif
                RELEASE:
                    if (!i_startDelay) begin
                        state_q <= IDLE;
                        o_busy  <= 1'b0;
                    end
                default: begin
                    state_q <= IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
endmodule

// File: tb/tb_prbs_delay_timer.sv
// tb_prbs_delay_timer: directed checks of capture, countdown, abort, release and reset behaviour.
module tb_prbs_delay_timer;
    logic i_clk = 1'b0;
    logic i_arst = 1'b1;
    logic i_tick = 1'b0;
    logic i_rstPRBS = 1'b0;
    logic i_enPRBS = 1'b0;
    logic i_startDelay = 1'b0;
    logic o_delayComplete;
    logic o_busy;
`ifdef PRBS_DELAY_REACTION_EN
    logic        i_react = 1'b0;
    logic [15:0] o_reactTicks;
    logic        o_reactValid;
`endif
    int checks = 0;
    int fails = 0;

    prbs_delay_timer #(
        .LFSR_W(10), .SEED(10'h001), .CNT_W(16), .MIN_TICKS(16'd4)
    ) dut (
        .i_clk(i_clk), .i_arst(i_arst), .i_tick(i_tick),
        .i_rstPRBS(i_rstPRBS), .i_enPRBS(i_enPRBS), .i_startDelay(i_startDelay),
        .o_delayComplete(o_delayComplete), .o_busy(o_busy)
`ifdef PRBS_DELAY_REACTION_EN
        , .i_react(i_react), .o_reactTicks(o_reactTicks), .o_reactValid(o_reactValid)
`endif
    );

    always #5 i_clk = ~i_clk;

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_ticks(input int k);
        i_tick = 1'b1;
        repeat (k) cyc();
        i_tick = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        cyc();
        cyc();
        i_arst = 1'b0;
        chk("rst_busy", 16'(o_busy), 16'd0);
        chk("rst_done", 16'(o_delayComplete), 16'd0);
        chk("rst_lfsr", 16'(dut.lfsr_q), 16'h001);
        chk("rst_cnt", dut.cnt_q, 16'd0);

        i_rstPRBS = 1'b1;
        cyc();
        i_rstPRBS = 1'b0;
        i_startDelay = 1'b1;
        cyc();
        chk("t1_busy", 16'(o_busy), 16'd1);
        chk("t1_cnt", dut.cnt_q, 16'd5);
        do_ticks(2);
        cyc();
        chk("t1_hold_cnt", dut.cnt_q, 16'd3);
        do_ticks(2);
        chk("t1_early", 16'(o_delayComplete), 16'd0);
        do_ticks(1);
        chk("t1_pulse", 16'(o_delayComplete), 16'd1);
        chk("t1_pulse_busy", 16'(o_busy), 16'd1);
        cyc();
        chk("t1_pulse_end", 16'(o_delayComplete), 16'd0);
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("t1_release_nopulse", 16'(o_delayComplete), 16'd0);
        end
        chk("t1_release_busy", 16'(o_busy), 16'd1);
        i_startDelay = 1'b0;
        cyc();
        chk("t1_idle_busy", 16'(o_busy), 16'd0);

        i_rstPRBS = 1'b1;
        cyc();
        i_rstPRBS = 1'b0;
        i_enPRBS = 1'b1;
        repeat (3) cyc();
        i_enPRBS = 1'b0;
        chk("t2_lfsr", 16'(dut.lfsr_q), 16'h008);
        i_startDelay = 1'b1;
        i_tick = 1'b1;
        cyc();
        i_tick = 1'b0;
        chk("t2_capture_tick_ignored", dut.cnt_q, 16'd12);
        do_ticks(11);
        chk("t2_early", 16'(o_delayComplete), 16'd0);
        do_ticks(1);
        chk("t2_pulse", 16'(o_delayComplete), 16'd1);
        cyc();
        i_startDelay = 1'b0;
        cyc();
        chk("t2_idle_busy", 16'(o_busy), 16'd0);

        i_startDelay = 1'b1;
        cyc();
        do_ticks(3);
        chk("t3_cnt", dut.cnt_q, 16'd9);
        i_tick = 1'b1;
        i_startDelay = 1'b0;
        cyc();
        i_tick = 1'b0;
        chk("t3_abort_busy", 16'(o_busy), 16'd0);
        chk("t3_abort_nopulse", 16'(o_delayComplete), 16'd0);
        chk("t3_abort_cnt", dut.cnt_q, 16'd9);
        i_enPRBS = 1'b1;
        cyc();
        i_enPRBS = 1'b0;
        chk("t3_lfsr", 16'(dut.lfsr_q), 16'h010);
        i_startDelay = 1'b1;
        cyc();
        chk("t3_recapture", dut.cnt_q, 16'd20);
        do_ticks(19);
        chk("t3_early", 16'(o_delayComplete), 16'd0);
        do_ticks(1);
        chk("t3_pulse", 16'(o_delayComplete), 16'd1);
        cyc();
        i_startDelay = 1'b0;
        cyc();
        chk("t3_idle_busy", 16'(o_busy), 16'd0);

        i_enPRBS = 1'b1;
        repeat (3) cyc();
        i_enPRBS = 1'b0;
        chk("t5_lfsr_tap", 16'(dut.lfsr_q), 16'h081);
        i_startDelay = 1'b1;
        cyc();
        chk("t5_cnt", dut.cnt_q, 16'd133);
        do_ticks(2);
        chk("t5_busy", 16'(o_busy), 16'd1);
        #2 i_arst = 1'b1;
        #1;
        chk("t5_arst_busy", 16'(o_busy), 16'd0);
        chk("t5_arst_lfsr", 16'(dut.lfsr_q), 16'h001);
        chk("t5_arst_cnt", dut.cnt_q, 16'd0);
        chk("t5_arst_state", 16'(dut.state_q), 16'd0);
        cyc();
        i_arst = 1'b0;
        i_startDelay = 1'b0;
        cyc();
        chk("t5_after_busy", 16'(o_busy), 16'd0);

`ifdef PRBS_DELAY_REACTION_EN
        i_startDelay = 1'b1;
        cyc();
        do_ticks(5);
        chk("r1_pulse", 16'(o_delayComplete), 16'd1);
        cyc();
        do_ticks(7);
        i_react = 1'b1;
        cyc();
        i_react = 1'b0;
        chk("r1_valid", 16'(o_reactValid), 16'd1);
        chk("r1_ticks", o_reactTicks, 16'd7);
        cyc();
        chk("r1_valid_end", 16'(o_reactValid), 16'd0);
        chk("r1_release_busy", 16'(o_busy), 16'd1);
        i_startDelay = 1'b0;
        cyc();
        i_startDelay = 1'b1;
        cyc();
        do_ticks(5);
        cyc();
        do_ticks(70000);
        i_react = 1'b1;
        cyc();
        i_react = 1'b0;
        chk("r2_saturate", o_reactTicks, 16'hFFFF);
        i_startDelay = 1'b0;
        cyc();
`endif

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
